// File: rtl/ch_cbus_port_if.sv
// CBUS port signal bundle: the MB-side CBUS lines and the channel-side FIFO/write handshakes.
// Bit 0 is the MSB of every data word. Parity bit g covers data bits 6g..6g+5.
interface ch_cbus_port_if;
  logic [0:35] cbus_d_re_h;
  logic [0:5]  cbus_par_re_h;
  logic        cbus_word_valid_h;
  logic        crc_cbus_out_hold_h;
  logic [0:35] ch_rd_word_h;
  logic        ch_rd_perr_h;
  logic        ch_rd_valid_h;
  logic        ch_rd_take_h;
  logic [0:35] ch_wr_word_h;
  logic        ch_wr_req_h;
  logic        ch_wr_ack_h;
  logic        cbus_req_h;
  logic        cbus_grant_h;
  logic [0:35] cbus_d_te_h;
  logic [0:5]  cbus_par_te_h;
  logic        cbus_te_en_h;
  logic        par_err_h;
  logic        ovf_err_h;
  logic        err_clr_h;

  // Port block side
  modport slave (
    input  cbus_d_re_h, cbus_par_re_h, cbus_word_valid_h, ch_rd_take_h,
           ch_wr_word_h, ch_wr_req_h, cbus_grant_h, err_clr_h,
    output crc_cbus_out_hold_h, ch_rd_word_h, ch_rd_perr_h, ch_rd_valid_h,
           ch_wr_ack_h, cbus_req_h, cbus_d_te_h, cbus_par_te_h, cbus_te_en_h,
           par_err_h, ovf_err_h
  );

  // MB / channel side
  modport master (
    output cbus_d_re_h, cbus_par_re_h, cbus_word_valid_h, ch_rd_take_h,
           ch_wr_word_h, ch_wr_req_h, cbus_grant_h, err_clr_h,
    input  crc_cbus_out_hold_h, ch_rd_word_h, ch_rd_perr_h, ch_rd_valid_h,
           ch_wr_ack_h, cbus_req_h, cbus_d_te_h, cbus_par_te_h, cbus_te_en_h,
           par_err_h, ovf_err_h
  );
endinterface

// File: rtl/ch_cbus_port.sv
// Channel CBUS port: 4-deep receive FIFO with parity checking and flow-control hold,
// plus a request/grant transmit FSM that drives one word onto the CBUS per channel write.
module ch_cbus_port (
  input logic          clk_ch_h,
  input logic          crobar_h,
  ch_cbus_port_if.slave bus
);

  localparam int DATA_W = 36;
  localparam int GRP_W  = 6;
  localparam int NGRP   = DATA_W / GRP_W;

  typedef enum logic [1:0] {IDLE, REQ, DRIVE, ACK} state_t;

  // Odd parity per 6-bit group (group XOR parity bit must be 1)
  function automatic logic [0:NGRP-1] odd_par(input logic [0:DATA_W-1] w);
    logic [0:NGRP-1] p;
    for (int g = 0; g < NGRP; g++) p[g] = ~^w[g*GRP_W +: GRP_W];
    return p;
  endfunction

  // True when any group fails the odd-parity check
  function automatic logic bad_par(input logic [0:DATA_W-1] w, input logic [0:NGRP-1] p);
    logic bad;
    bad = 1'b0;
    for (int g = 0; g < NGRP; g++) bad |= ~(^{w[g*GRP_W +: GRP_W], p[g]});
    return bad;
  endfunction

  logic [0:DATA_W-1] mem_d [4];
  logic              mem_perr [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        cnt, cnt_nxt;
  logic              push, pop, drop, rx_bad;
  logic              hold_q, par_err_q, ovf_err_q;
  logic [0:DATA_W-1] tx_word;
  state_t            state, state_nxt;

  // Receive-side decode: a pop frees a slot for a same-cycle word even when full
  always_comb begin
    pop     = bus.ch_rd_take_h && (cnt != 3'd0);
    push    = bus.cbus_word_valid_h && ((cnt != 3'd4) || pop);
    drop    = bus.cbus_word_valid_h && !push;
    rx_bad  = bad_par(bus.cbus_d_re_h, bus.cbus_par_re_h);
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 3'd1;
      2'b01:   cnt_nxt = cnt - 3'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  // FIFO storage; contents are meaningless while cnt says empty, so no reset
  always_ff @(posedge clk_ch_h) begin
    if (push) begin
      mem_d[wr_ptr]    <= bus.cbus_d_re_h;
      mem_perr[wr_ptr] <= rx_bad;
    end
  end

  // FIFO pointers, occupancy, hold and sticky error flags (set beats clear)
  always_ff @(posedge clk_ch_h or posedge crobar_h) begin
    if (crobar_h) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      cnt       <= 3'd0;
      hold_q    <= 1'b0;
      par_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      cnt       <= cnt_nxt;
      hold_q    <= (cnt_nxt >= 3'd2);
      par_err_q <= (push && rx_bad) || (par_err_q && !bus.err_clr_h);
      ovf_err_q <= drop || (ovf_err_q && !bus.err_clr_h);
    end
  end

  assign bus.ch_rd_valid_h       = (cnt != 3'd0);
  assign bus.ch_rd_word_h        = mem_d[rd_ptr];
  assign bus.ch_rd_perr_h        = mem_perr[rd_ptr];
  assign bus.crc_cbus_out_hold_h = hold_q;
  assign bus.par_err_h           = par_err_q;
  assign bus.ovf_err_h           = ovf_err_q;

  // Transmit FSM state register
  always_ff @(posedge clk_ch_h or posedge crobar_h) begin
    if (crobar_h) state <= IDLE;
    else          state <= state_nxt;
  end

  // Transmit word capture; only observable while in DRIVE, so no reset
  always_ff @(posedge clk_ch_h) begin
    if (state == IDLE && bus.ch_wr_req_h) tx_word <= bus.ch_wr_word_h;
  end

  // Transmit next-state: a grant that collides with an incoming word is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ch_wr_req_h) state_nxt = REQ;
      REQ:     if (bus.cbus_grant_h && !bus.cbus_word_valid_h) state_nxt = DRIVE;
      DRIVE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transmit outputs: bus lines are zero except during the single DRIVE cycle
  always_comb begin
    bus.cbus_req_h    = 1'b0;
    bus.cbus_te_en_h  = 1'b0;
    bus.cbus_d_te_h   = '0;
    bus.cbus_par_te_h = '0;
    bus.ch_wr_ack_h   = 1'b0;
    case (state)
      REQ:   bus.cbus_req_h = 1'b1;
      DRIVE: begin
        bus.cbus_req_h    = 1'b1;
        bus.cbus_te_en_h  = 1'b1;
        bus.cbus_d_te_h   = tx_word;
        bus.cbus_par_te_h = odd_par(tx_word);
      end
      ACK:   bus.ch_wr_ack_h = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ch_cbus_port.sv
// Directed bench for ch_cbus_port: receive FIFO order/parity/overflow, transmit handshake, reset.
module tb_ch_cbus_port;

  logic clk_ch_h = 1'b0;
  logic crobar_h = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ch_cbus_port_if bus ();

  ch_cbus_port dut (
    .clk_ch_h (clk_ch_h),
    .crobar_h (crobar_h),
    .bus      (bus.slave)
  );

  always #5 clk_ch_h = ~clk_ch_h;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk36(input string tag, input logic [0:35] obs, input logic [0:35] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [0:5] obs, input logic [0:5] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ch_h);
    #1;
  endtask

  task automatic send(input logic [0:35] w, input logic [0:5] p);
    bus.cbus_d_re_h       = w;
    bus.cbus_par_re_h     = p;
    bus.cbus_word_valid_h = 1'b1;
    step();
    bus.cbus_word_valid_h = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [0:35] w, input logic perr);
    chk1({tag, "_valid"}, bus.ch_rd_valid_h, 1'b1);
    chk36({tag, "_word"}, bus.ch_rd_word_h, w);
    chk1({tag, "_perr"}, bus.ch_rd_perr_h, perr);
    bus.ch_rd_take_h = 1'b1;
    step();
    bus.ch_rd_take_h = 1'b0;
  endtask

  initial begin
    bus.cbus_d_re_h       = '0;
    bus.cbus_par_re_h     = '0;
    bus.cbus_word_valid_h = 1'b0;
    bus.ch_rd_take_h      = 1'b0;
    bus.ch_wr_word_h      = '0;
    bus.ch_wr_req_h       = 1'b0;
    bus.cbus_grant_h      = 1'b0;
    bus.err_clr_h         = 1'b0;

    // reset state
    step(); step();
    chk1("rst_valid", bus.ch_rd_valid_h, 1'b0);
    chk1("rst_hold", bus.crc_cbus_out_hold_h, 1'b0);
    chk1("rst_parerr", bus.par_err_h, 1'b0);
    chk1("rst_ovferr", bus.ovf_err_h, 1'b0);
    chk1("rst_req", bus.cbus_req_h, 1'b0);
    chk1("rst_te_en", bus.cbus_te_en_h, 1'b0);
    chk1("rst_ack", bus.ch_wr_ack_h, 1'b0);
    chk36("rst_d_te", bus.cbus_d_te_h, 36'o0);
    crobar_h = 1'b0;
    step();

    // three good words, in-order pop, hold after the second
    send(36'o123456701234, 6'b101010);
    chk1("w1_valid", bus.ch_rd_valid_h, 1'b1);
    chk1("w1_hold", bus.crc_cbus_out_hold_h, 1'b0);
    send(36'o000000000000, 6'b111111);
    chk1("w2_hold", bus.crc_cbus_out_hold_h, 1'b1);
    send(36'o777777777777, 6'b111111);
    chk1("w3_hold", bus.crc_cbus_out_hold_h, 1'b1);
    pop_chk("p1", 36'o123456701234, 1'b0);
    chk1("p1_hold", bus.crc_cbus_out_hold_h, 1'b1);
    pop_chk("p2", 36'o000000000000, 1'b0);
    chk1("p2_hold", bus.crc_cbus_out_hold_h, 1'b0);
    pop_chk("p3", 36'o777777777777, 1'b0);
    chk1("p3_empty", bus.ch_rd_valid_h, 1'b0);
    chk1("p3_parerr", bus.par_err_h, 1'b0);
    // take while empty is ignored
    bus.ch_rd_take_h = 1'b1;
    step();
    bus.ch_rd_take_h = 1'b0;
    chk1("empty_take_valid", bus.ch_rd_valid_h, 1'b0);

    // overflow: fifth word dropped
    send(36'o000000000001, 6'b111110);
    send(36'o000000000002, 6'b111110);
    send(36'o000000000003, 6'b111111);
    send(36'o000000000004, 6'b111110);
    chk1("full_ovf_pre", bus.ovf_err_h, 1'b0);
    send(36'o000000000005, 6'b111111);
    chk1("ovf_set", bus.ovf_err_h, 1'b1);
    chk36("ovf_head", bus.ch_rd_word_h, 36'o000000000001);
    bus.err_clr_h = 1'b1;
    step();
    bus.err_clr_h = 1'b0;
    chk1("ovf_clr", bus.ovf_err_h, 1'b0);
    // write and pop together while full: word accepted, no overflow
    bus.ch_rd_take_h = 1'b1;
    send(36'o000000000007, 6'b111110);
    bus.ch_rd_take_h = 1'b0;
    chk1("full_wrpop_ovf", bus.ovf_err_h, 1'b0);
    pop_chk("f2", 36'o000000000002, 1'b0);
    pop_chk("f3", 36'o000000000003, 1'b0);
    pop_chk("f4", 36'o000000000004, 1'b0);
    pop_chk("f7", 36'o000000000007, 1'b0);
    chk1("f_empty", bus.ch_rd_valid_h, 1'b0);

    // bad parity in group 5
    send(36'o000000000001, 6'b111111);
    chk1("perr_sticky", bus.par_err_h, 1'b1);
    // second bad word with a same-cycle clear: set wins
    bus.err_clr_h = 1'b1;
    send(36'o000000000000, 6'b011111);
    bus.err_clr_h = 1'b0;
    chk1("perr_set_wins", bus.par_err_h, 1'b1);
    bus.err_clr_h = 1'b1;
    step();
    bus.err_clr_h = 1'b0;
    chk1("perr_clr", bus.par_err_h, 1'b0);
    pop_chk("b1", 36'o000000000001, 1'b1);
    pop_chk("b2", 36'o000000000000, 1'b1);

    // transmit with grant held high
    bus.cbus_grant_h = 1'b1;
    bus.ch_wr_word_h = 36'o400000000000;
    bus.ch_wr_req_h  = 1'b1;
    step();
    bus.ch_wr_req_h  = 1'b0;
    bus.ch_wr_word_h = '0;
    chk1("tx_req", bus.cbus_req_h, 1'b1);
    chk1("tx_req_te", bus.cbus_te_en_h, 1'b0);
    step();
    chk1("tx_drive_te", bus.cbus_te_en_h, 1'b1);
    chk36("tx_drive_d", bus.cbus_d_te_h, 36'o400000000000);
    chk6("tx_drive_par", bus.cbus_par_te_h, 6'b011111);
    chk1("tx_drive_req", bus.cbus_req_h, 1'b1);
    chk1("tx_drive_ack", bus.ch_wr_ack_h, 1'b0);
    step();
    chk1("tx_ack", bus.ch_wr_ack_h, 1'b1);
    chk1("tx_ack_req", bus.cbus_req_h, 1'b0);
    chk1("tx_ack_te", bus.cbus_te_en_h, 1'b0);
    chk36("tx_ack_d", bus.cbus_d_te_h, 36'o0);
    chk6("tx_ack_par", bus.cbus_par_te_h, 6'b000000);
    step();
    chk1("tx_idle_ack", bus.ch_wr_ack_h, 1'b0);

    // grant colliding with an incoming word is ignored
    bus.ch_wr_word_h = 36'o000000000003;
    bus.ch_wr_req_h  = 1'b1;
    step();
    bus.ch_wr_req_h  = 1'b0;
    send(36'o000000000000, 6'b111111);
    chk1("coll_no_drive", bus.cbus_te_en_h, 1'b0);
    chk1("coll_req", bus.cbus_req_h, 1'b1);
    chk1("coll_stored", bus.ch_rd_valid_h, 1'b1);
    step();
    chk1("coll_drive", bus.cbus_te_en_h, 1'b1);
    chk6("coll_par", bus.cbus_par_te_h, 6'b111111);
    step();
    chk1("coll_ack", bus.ch_wr_ack_h, 1'b1);
    pop_chk("c1", 36'o000000000000, 1'b0);

    // reset during DRIVE with two words queued
    send(36'o000000000001, 6'b111110);
    send(36'o000000000002, 6'b111110);
    bus.ch_wr_word_h = 36'o123456701234;
    bus.ch_wr_req_h  = 1'b1;
    step();
    bus.ch_wr_req_h  = 1'b0;
    step();
    chk1("r_pre_drive", bus.cbus_te_en_h, 1'b1);
    chk1("r_pre_hold", bus.crc_cbus_out_hold_h, 1'b1);
    #2;
    crobar_h = 1'b1;
    #1;
    chk1("r_te_en", bus.cbus_te_en_h, 1'b0);
    chk1("r_req", bus.cbus_req_h, 1'b0);
    chk36("r_d_te", bus.cbus_d_te_h, 36'o0);
    chk1("r_valid", bus.ch_rd_valid_h, 1'b0);
    chk1("r_hold", bus.crc_cbus_out_hold_h, 1'b0);
    step();
    crobar_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("r_no_ack", bus.ch_wr_ack_h, 1'b0);
      chk1("r_still_empty", bus.ch_rd_valid_h, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
